pcm_i2s_tx: RTL and testbench

PCM_I2S_TX -- requirements
Module: pcm_i2s_tx

---
 rtl/pcm_i2s_tx_if.sv | 25 ++
 rtl/pcm_i2s_tx.sv | 92 +++++++++
 tb/tb_pcm_i2s_tx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pcm_i2s_tx_if.sv
// Signal bundle between the PCM sample source and the I2S transmitter:
// held sample/mute inputs plus the serial, HDMI-side and timing outputs.
interface pcm_i2s_tx_if #(
  parameter int AUDIO_BITS = 16
);
  logic [AUDIO_BITS-1:0] pcm_l;
  logic [AUDIO_BITS-1:0] pcm_r;
  logic                  mute;
  logic                  bclk;
  logic                  lrclk;
  logic                  sdata;
  logic [AUDIO_BITS-1:0] pcm_out;
  logic                  clken;
  logic                  acr;

  modport master (
    output pcm_l, pcm_r, mute,
    input  bclk, lrclk, sdata, pcm_out, clken, acr
  );

  modport slave (
    input  pcm_l, pcm_r, mute,
    output bclk, lrclk, sdata, pcm_out, clken, acr
  );
endinterface

// File: rtl/pcm_i2s_tx.sv
// I2S (Philips) transmitter running off MCLK = 256 x fs: 64 bit-clock slots per
// frame, one frame-rate clock enable and an ACR pulse every ACR_FRAMES frames.
module pcm_i2s_tx #(
  parameter int AUDIO_BITS = 16,
  parameter int ACR_FRAMES = 48
) (
  input  logic         clk,
  input  logic         reset,
  pcm_i2s_tx_if.slave  bus
);
  localparam logic [7:0] ACR_LAST = 8'(ACR_FRAMES - 1);

  logic [1:0]            d;
  logic [1:0]            d_nxt;
  logic [5:0]            b;
  logic [5:0]            b_nxt;
  logic [AUDIO_BITS-1:0] shadow_l;
  logic [AUDIO_BITS-1:0] shadow_r;
  logic [AUDIO_BITS-1:0] shadow_l_nxt;
  logic [AUDIO_BITS-1:0] shadow_r_nxt;
  logic [AUDIO_BITS-1:0] word_sel;
  logic [AUDIO_BITS-1:0] word_shift;
  logic [7:0]            frame_cnt;
  logic                  latch_now;
  logic                  bclk_q;
  logic                  lrclk_q;
  logic                  sdata_q;
  logic                  clken_q;
  logic                  acr_q;
  logic                  bclk_nxt;
  logic                  lrclk_nxt;
  logic                  sdata_nxt;
  logic                  clken_nxt;
  logic                  acr_nxt;

  // Outputs are registered from the counter/shadow values of the coming cycle,
  // so each output flop shows exactly what belongs to the current (d,b).
  always_comb begin
    d_nxt        = d + 2'd1;
    b_nxt        = (d == 2'd3) ? b + 6'd1 : b;
    latch_now    = (d == 2'd3) && (b == 6'd63);
    shadow_l_nxt = shadow_l;
    shadow_r_nxt = shadow_r;
    if (latch_now) begin
      shadow_l_nxt = bus.mute ? '0 : bus.pcm_l;
      shadow_r_nxt = bus.mute ? '0 : bus.pcm_r;
    end
    word_sel   = b_nxt[5] ? shadow_r_nxt : shadow_l_nxt;
    // Bits at or beyond AUDIO_BITS shift out to zero, padding the slot tail.
    word_shift = word_sel << b_nxt[4:0];
    bclk_nxt   = d_nxt[1];
    lrclk_nxt  = (b_nxt >= 6'd31) && (b_nxt <= 6'd62);
    sdata_nxt  = word_shift[AUDIO_BITS-1];
    clken_nxt  = (d_nxt == 2'd3) && (b_nxt == 6'd63);
    acr_nxt    = clken_nxt && (frame_cnt == ACR_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d         <= '0;
      b         <= '0;
      shadow_l  <= '0;
      shadow_r  <= '0;
      frame_cnt <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      clken_q   <= 1'b0;
      acr_q     <= 1'b0;
    end else begin
      d        <= d_nxt;
      b        <= b_nxt;
      shadow_l <= shadow_l_nxt;
      shadow_r <= shadow_r_nxt;
      bclk_q   <= bclk_nxt;
      lrclk_q  <= lrclk_nxt;
      sdata_q  <= sdata_nxt;
      clken_q  <= clken_nxt;
      acr_q    <= acr_nxt;
      if (latch_now) begin
        frame_cnt <= (frame_cnt == ACR_LAST) ? 8'd0 : frame_cnt + 8'd1;
      end
    end
  end

  assign bus.bclk    = bclk_q;
  assign bus.lrclk   = lrclk_q;
  assign bus.sdata   = sdata_q;
  assign bus.clken   = clken_q;
  assign bus.acr     = acr_q;
  assign bus.pcm_out = shadow_l;
endmodule

// File: tb/tb_pcm_i2s_tx.sv
// Frame-level bench for pcm_i2s_tx: expected frame words are queued when the
// samples are presented and compared against the deserialised sdata stream.
module tb_pcm_i2s_tx;
  localparam int AUDIO_BITS = 16;
  localparam int ACR_FRAMES = 48;

  typedef struct packed {
    logic [31:0] left_word;
    logic [31:0] right_word;
    logic [15:0] pcm_out;
  } frame_exp_t;

  logic clk = 1'b0;
  logic reset;

  pcm_i2s_tx_if #(.AUDIO_BITS(AUDIO_BITS)) bus ();

  pcm_i2s_tx #(
    .AUDIO_BITS(AUDIO_BITS),
    .ACR_FRAMES(ACR_FRAMES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         checks_total   = 0;
  int         checks_passed  = 0;
  int         cyc            = 0;
  int         frame_idx      = 0;
  int         clken_total    = 0;
  int         clken_at_12287 = -1;
  int         acr_cycles[$];
  frame_exp_t sb[$];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_total++;
    assert (obs === exp_v) checks_passed++;
    else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic apply_stimulus(input logic [15:0] l, input logic [15:0] r, input logic m);
    bus.pcm_l = l;
    bus.pcm_r = r;
    bus.mute  = m;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_bclk"},    32'(bus.bclk),    32'd0);
    check_output({tag, "_lrclk"},   32'(bus.lrclk),   32'd0);
    check_output({tag, "_sdata"},   32'(bus.sdata),   32'd0);
    check_output({tag, "_clken"},   32'(bus.clken),   32'd0);
    check_output({tag, "_acr"},     32'(bus.acr),     32'd0);
    check_output({tag, "_pcm_out"}, 32'(bus.pcm_out), 32'd0);
  endtask

  // Runs one full frame from slot 0, d=0. The next frame's samples are presented
  // at slot 5; with glitch=1 they are disturbed mid-frame and mute is only
  // settled in the latch cycle itself.
  task automatic run_frame(input logic [15:0] nl, input logic [15:0] nr, input logic nm,
                           input logic glitch);
    logic [31:0] lw;
    logic [31:0] rw;
    logic        prev_sdata;
    logic        exp_bit;
    int          bad_bclk, bad_lr, bad_clken, bad_acr, bad_pcm, bad_hold;
    int          s;
    frame_exp_t  e;
    frame_exp_t  nxt;
    lw = '0;
    rw = '0;
    prev_sdata = 1'b0;
    bad_bclk = 0; bad_lr = 0; bad_clken = 0; bad_acr = 0; bad_pcm = 0; bad_hold = 0;
    e = '0;
    check_output($sformatf("f%0d_sb_depth", frame_idx), 32'(sb.size()), 32'd1);
    if (sb.size() != 0) e = sb.pop_front();
    for (int p = 0; p < 256; p++) begin
      s = p / 4;
      exp_bit = ((p % 4) >= 2);
      if (bus.bclk !== exp_bit) bad_bclk++;
      exp_bit = (s >= 31) && (s <= 62);
      if (bus.lrclk !== exp_bit) bad_lr++;
      exp_bit = (p == 255);
      if (bus.clken !== exp_bit) bad_clken++;
      exp_bit = (p == 255) && ((frame_idx % ACR_FRAMES) == ACR_FRAMES - 1);
      if (bus.acr !== exp_bit) bad_acr++;
      if (bus.pcm_out !== e.pcm_out) bad_pcm++;
      if ((p % 4) != 0 && bus.sdata !== prev_sdata) bad_hold++;
      prev_sdata = bus.sdata;
      if ((p % 4) == 2) begin
        if (s < 32) lw[31 - s] = bus.sdata;
        else        rw[63 - s] = bus.sdata;
      end
      if (bus.clken === 1'b1) clken_total++;
      if (bus.acr === 1'b1) acr_cycles.push_back(cyc);
      if (cyc == 12287) clken_at_12287 = clken_total;
      if (p == 20) apply_stimulus(nl, nr, nm);
      if (glitch && p == 100) apply_stimulus(16'($urandom), 16'($urandom), 1'($urandom));
      if (glitch && p == 200) apply_stimulus(nl, nr, ~nm);
      if (p == 255) begin
        bus.mute = nm;
        nxt.left_word  = nm ? 32'd0 : {nl, 16'h0000};
        nxt.right_word = nm ? 32'd0 : {nr, 16'h0000};
        nxt.pcm_out    = nm ? 16'd0 : nl;
        sb.push_back(nxt);
      end
      step();
    end
    check_output($sformatf("f%0d_left", frame_idx),    lw, e.left_word);
    check_output($sformatf("f%0d_right", frame_idx),   rw, e.right_word);
    check_output($sformatf("f%0d_bclk", frame_idx),    32'(bad_bclk), 32'd0);
    check_output($sformatf("f%0d_lrclk", frame_idx),   32'(bad_lr), 32'd0);
    check_output($sformatf("f%0d_clken", frame_idx),   32'(bad_clken), 32'd0);
    check_output($sformatf("f%0d_acr", frame_idx),     32'(bad_acr), 32'd0);
    check_output($sformatf("f%0d_pcm_out", frame_idx), 32'(bad_pcm), 32'd0);
    check_output($sformatf("f%0d_sdata_hold", frame_idx), 32'(bad_hold), 32'd0);
    frame_idx++;
  endtask

  initial begin
    frame_exp_t zero_frame;
    zero_frame = '0;
    $display("[TB] pcm_i2s_tx bench starting");
    reset = 1'b1;
    apply_stimulus(16'h1234, 16'h5678, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check_all_zero("reset");

    // First cycle after release is (0,0); frame 0 must carry zeros.
    reset = 1'b0;
    cyc = 0;
    frame_idx = 0;
    sb.push_back(zero_frame);
    apply_stimulus(16'hA5C3, 16'h8001, 1'b0);
    run_frame(16'hA5C3, 16'h8001, 1'b0, 1'b0);
    run_frame(16'h7FFF, 16'h8001, 1'b0, 1'b0);
    run_frame(16'h7FFF, 16'h8001, 1'b1, 1'b0);
    run_frame(16'h7FFF, 16'h8001, 1'b0, 1'b0);
    for (int f = 4; f < 97; f++) begin
      run_frame(16'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0), 1'b1);
    end

    check_output("clken_by_12287", 32'(clken_at_12287), 32'd48);
    check_output("acr_count", 32'(acr_cycles.size()), 32'd2);
    check_output("acr_first",  (acr_cycles.size() > 0) ? 32'(acr_cycles[0]) : 32'hFFFF_FFFF, 32'd12287);
    check_output("acr_second", (acr_cycles.size() > 1) ? 32'(acr_cycles[1]) : 32'hFFFF_FFFF, 32'd24575);

    // One-cycle reset at slot 40 of a frame already carrying nonzero samples.
    apply_stimulus(16'hFFFF, 16'hFFFF, 1'b0);
    repeat (160) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    cyc = 0;
    check_all_zero("midreset");
    sb.delete();
    sb.push_back(zero_frame);
    frame_idx = 0;
    run_frame(16'h1111, 16'h2222, 1'b0, 1'b1);
    run_frame(16'h3333, 16'h4444, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
